// File: rtl/pspin_her_conf_seq.sv
`default_nettype none
// =============================================================================
// Module   : pspin_her_conf_seq
// Gates DMA completions, drains in-flight HERs, then strobes conf_valid.
// Optional drain timeout: define PSPIN_HER_CONF_TIMEOUT_EN.
// Revision : 1.0
// =============================================================================
module pspin_her_conf_seq #(
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ctrl_commit_valid,
    output logic                 ctrl_commit_ready,
    output logic                 ctrl_busy,
    output logic [CNT_WIDTH-1:0] ctrl_outstanding,
    output logic                 ctrl_timeout,
    input  logic                 ctrl_timeout_clr,
    input  logic                 s_gen_valid,
    output logic                 s_gen_ready,
    output logic                 m_gen_valid,
    input  logic                 m_gen_ready,
    input  logic                 her_valid,
    input  logic                 her_ready,
    input  logic                 fb_valid,
    output logic                 conf_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 conf_valid_q, conf_valid_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;

    logic gate_open;
    logic commit_fire;
    logic her_fire;
    logic drain_expired;
    logic timeout_clr;

    // Completions only flow while idle; a commit never preempts a pending transfer.
    assign gate_open         = (state_q == ST_IDLE);
    assign m_gen_valid       = gate_open & s_gen_valid;
    assign s_gen_ready       = gate_open & m_gen_ready;
    assign ctrl_commit_ready = gate_open & (~s_gen_valid | m_gen_ready);
    assign commit_fire       = ctrl_commit_valid & ctrl_commit_ready;
    assign her_fire          = her_valid & her_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (her_fire && !fb_valid && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (fb_valid && !her_fire && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

`ifdef PSPIN_HER_CONF_TIMEOUT_EN
    localparam int unsigned   DW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(TIMEOUT_CYCLES - 1);

    logic [DW-1:0] drain_cnt_q, drain_cnt_d;

    // Held at zero outside DRAIN, so every DRAIN entry starts from a clean count.
    always_comb begin
        drain_cnt_d = '0;
        if ((state_q == ST_DRAIN) && (drain_cnt_q != DRAIN_LAST)) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drain_cnt_q <= '0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign drain_expired = (state_q == ST_DRAIN) && (drain_cnt_q == DRAIN_LAST);
    assign timeout_clr   = ctrl_timeout_clr;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ctrl_timeout_clr ^ (TIMEOUT_CYCLES == 0);
    assign drain_expired      = 1'b0;
    assign timeout_clr        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        if (timeout_clr) begin
            timeout_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (commit_fire) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_COMMIT;
                end else if (drain_expired) begin
                    state_d   = ST_COMMIT;
                    timeout_d = 1'b1;
                end
            end
            ST_COMMIT: state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        conf_valid_d = (state_d == ST_COMMIT);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            conf_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            conf_valid_q <= conf_valid_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign conf_valid       = conf_valid_q;
    assign ctrl_busy        = busy_q;
    assign ctrl_outstanding = cnt_q;
    assign ctrl_timeout     = timeout_q;

endmodule
`default_nettype wire

// File: doc/pspin_her_conf_seq.md
# pspin_her_conf_seq

Quiesce-and-commit sequencer for the PsPIN HER generator's execution-context configuration. It sits between the ingress DMA completion stream and the HER generator, and between the control registers and the generator's `conf_valid` latch strobe. On a commit request it gates new completions and waits until all issued HERs have been retired by PsPIN feedback. It then pulses `conf_valid` and releases the gate, so no in-flight handler ever observes a context that changed underneath it.

## Interface
Parameters:
- `CNT_WIDTH`, 16, width of outstanding-HER counter
- `TIMEOUT_CYCLES`, 65536, drain timeout in cycles (used only with `PSPIN_HER_CONF_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low
- `ctrl_commit_valid`  in  1  commit request from control registers
- `ctrl_commit_ready`  out  1  commit accepted when both valid and ready are high
- `ctrl_busy`  out  1  sequence in progress (state != IDLE)
- `ctrl_outstanding`  out  CNT_WIDTH  current outstanding-HER count
- `ctrl_timeout`  out  1  sticky: last drain ended by timeout
- `ctrl_timeout_clr`  in  1  clears `ctrl_timeout`
- `s_gen_valid` / `s_gen_ready`  in/out  1  completion handshake from ingress DMA
- `m_gen_valid` / `m_gen_ready`  out/in  1  completion handshake to HER generator
- `her_valid`, `her_ready`  in  1  monitored HER handshake to PsPIN
- `fb_valid`  in  1  handler-completion feedback from PsPIN, one pulse per retired HER
- `conf_valid`  out  1  one-cycle latch strobe to HER generator

## Operation
- States: IDLE, DRAIN, COMMIT, SETTLE.
- IDLE: pass-through. `m_gen_valid = s_gen_valid`, `s_gen_ready = m_gen_ready` (combinational).
- `ctrl_commit_ready = (state==IDLE) && (!s_gen_valid || m_gen_ready)`. A commit is never taken while a completion is presented but not accepted, so valid is never withdrawn.
- Commit handshake in IDLE moves the FSM to DRAIN.
- DRAIN, COMMIT, SETTLE: gate closed (`m_gen_valid=0`, `s_gen_ready=0`).
- DRAIN: when `ctrl_outstanding==0`, go to COMMIT.
- COMMIT: `conf_valid=1` for exactly one cycle, then SETTLE.
- SETTLE: one cycle so the generator's stores are updated, then IDLE.
- Outstanding counter:
  - +1 on `her_valid && her_ready`; −1 on `fb_valid`.
  - Both in the same cycle: unchanged.
  - Saturates at 2^CNT_WIDTH−1 (no wrap).
  - Decrement at 0 holds 0.
  - Counts in all states.
- Further `ctrl_commit_valid` while busy is back-pressured (ready=0), not dropped.

## Timing
- Reset values: state IDLE, `conf_valid` 0, `ctrl_busy` 0, `ctrl_outstanding` 0, `ctrl_timeout` 0.
- `conf_valid`, `ctrl_busy`, `ctrl_outstanding` and `ctrl_timeout` are registered.
- Commit accepted at edge T, outstanding 0: gate closed at T+1 (DRAIN), `conf_valid` high T+2, SETTLE T+3, gate reopens T+4. Minimum gate window is 3 cycles.
- A completion accepted in the same cycle as the commit is counted at T+1 and drained before commit.
- Asynchronous reset mid-sequence: immediate return to IDLE, counter cleared, no `conf_valid` pulse emitted.

## Configuration
- `PSPIN_HER_CONF_TIMEOUT_EN` defined:
  - A drain-cycle counter runs in DRAIN.
  - After TIMEOUT_CYCLES cycles in DRAIN with outstanding ≠ 0, the FSM goes to COMMIT anyway and sets `ctrl_timeout`.
  - Set has priority over `ctrl_timeout_clr` in the same cycle.
  - The drain counter is cleared on DRAIN entry.
- Undefined:
  - No drain counter; DRAIN waits indefinitely.
  - `ctrl_timeout` is tied 0 and `ctrl_timeout_clr` is ignored.

## Test plan
- Idle commit, outstanding 0: commit at cycle 10 -> `conf_valid` high only in cycle 12, `s_gen_ready` low cycles 11–13, high from 14.
- 3 HERs issued, commit, then `fb_valid` pulses at +5/+9/+20 -> `conf_valid` exactly 1 cycle after the counter reaches 0; no completion passes while gated.
- `s_gen_valid` high with `m_gen_ready` low plus commit request -> `ctrl_commit_ready`=0 until the transfer completes; commit then proceeds and outstanding=1.
- Simultaneous HER handshake and `fb_valid` with outstanding 2 -> stays 2. `fb_valid` at 0 -> stays 0. Saturation at 0xFFFF holds.
- `rstn` asserted in DRAIN -> all outputs at reset values immediately; no `conf_valid` after release.
- With `PSPIN_HER_CONF_TIMEOUT_EN`, TIMEOUT_CYCLES=16, outstanding stuck at 1 -> `conf_valid` 16 cycles after DRAIN entry; `ctrl_timeout`=1 until `ctrl_timeout_clr`.
